scale_addr_sequencer: RTL and testbench

Synthesizable controller for the nearest-neighbour image scaling datapath. Given source and destination frame dimensions and fixed-point inverse scale steps, it walks the destination frame in raster order and issues one request per destination pixel. Each request carries the source address to copy from, or a fill flag when the mapped source coordinate falls outside the source frame. It sits between the frame-level configuration registers and the pixel-mover that reads the source buffer and writes the destination buffer.

---
 rtl/scale_pkg.sv | 17 +
 rtl/scale_axis_stepper.sv | 46 ++++
 rtl/scale_addr_sequencer.sv | 124 ++++++++++++
 tb/tb_scale_addr_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared widths, FSM state and common types for the nearest-neighbour scaling address sequencer.
package scale_pkg;
  localparam int DIM_W  = 11;
  localparam int FRAC   = 8;
  localparam int AW     = 2 * DIM_W;
  localparam int ACC_W  = 2 * DIM_W + FRAC;
  localparam int STEP_W = DIM_W + FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DIM_W-1:0] dim_t;
  typedef logic [AW-1:0]    addr_t;
endpackage

// File: rtl/scale_axis_stepper.sv
// One scan axis: destination index counter plus fixed-point source accumulator,
// with end-of-axis flag and source bounds check. WRAP=1 returns to 0 after the last index.
module scale_axis_stepper #(
  parameter int DIM_W = 11,
  parameter int FRAC  = 8,
  parameter bit WRAP  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [DIM_W+FRAC-1:0] step,
  input  logic [DIM_W-1:0]      count,
  input  logic [DIM_W-1:0]      src_dim,
  output logic [DIM_W-1:0]      idx,
  output logic [DIM_W-1:0]      src_idx,
  output logic                  last,
  output logic                  oob
);
  localparam int ACC_W = 2 * DIM_W + FRAC;
  localparam int INT_W = ACC_W - FRAC;

  logic [ACC_W-1:0] acc;
  logic [INT_W-1:0] int_part;

  assign int_part = acc[ACC_W-1:FRAC];
  assign src_idx  = int_part[DIM_W-1:0];
  assign last     = (idx == count - DIM_W'(1));
  // Full-width compare so an accumulator that has run past the frame still reads as out of bounds.
  assign oob      = (int_part >= INT_W'(src_dim));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
      acc <= '0;
    end else if (advance) begin
      if (WRAP && last) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + DIM_W'(1);
        acc <= acc + ACC_W'(step);
      end
    end
  end
endmodule

// File: rtl/scale_addr_sequencer.sv
// Walks the destination frame in raster order and issues one copy/fill request per pixel.
// Request fields derive only from registers, so they hold steady while req_ready is low.
module scale_addr_sequencer #(
  parameter int DIM_W = 11,
  parameter int FRAC  = 8,
  parameter int AW    = 2 * DIM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      src_rows,
  input  logic [DIM_W-1:0]      src_cols,
  input  logic [DIM_W-1:0]      dst_rows,
  input  logic [DIM_W-1:0]      dst_cols,
  input  logic [DIM_W+FRAC-1:0] step_v,
  input  logic [DIM_W+FRAC-1:0] step_h,
  output logic                  busy,
  output logic                  done,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [AW-1:0]         req_src_addr,
  output logic [AW-1:0]         req_dst_addr,
  output logic                  req_fill,
  output logic                  req_last
);
  import scale_pkg::*;

  state_e state, state_nxt;

  logic [DIM_W-1:0]      cfg_src_rows, cfg_src_cols, cfg_dst_rows, cfg_dst_cols;
  logic [DIM_W+FRAC-1:0] cfg_step_v, cfg_step_h;

  logic             accept, xfer, run, fill;
  logic [DIM_W-1:0] i, j, src_i, src_j;
  logic             v_last, h_last, v_oob, h_oob;

  assign accept = (state == IDLE) && start;
  assign xfer   = req_valid && req_ready;
  assign run    = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (dst_rows == '0 || dst_cols == '0) ? DONE : RUN;
      RUN:  if (xfer && req_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    req_valid = run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_src_rows <= '0;
      cfg_src_cols <= '0;
      cfg_dst_rows <= '0;
      cfg_dst_cols <= '0;
      cfg_step_v   <= '0;
      cfg_step_h   <= '0;
    end else if (accept) begin
      cfg_src_rows <= src_rows;
      cfg_src_cols <= src_cols;
      cfg_dst_rows <= dst_rows;
      cfg_dst_cols <= dst_cols;
      cfg_step_v   <= step_v;
      cfg_step_h   <= step_h;
    end
  end

  scale_axis_stepper #(.DIM_W(DIM_W), .FRAC(FRAC), .WRAP(1'b1)) u_h (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (xfer),
    .step    (cfg_step_h),
    .count   (cfg_dst_cols),
    .src_dim (cfg_src_cols),
    .idx     (j),
    .src_idx (src_j),
    .last    (h_last),
    .oob     (h_oob)
  );

  scale_axis_stepper #(.DIM_W(DIM_W), .FRAC(FRAC), .WRAP(1'b0)) u_v (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (xfer && h_last),
    .step    (cfg_step_v),
    .count   (cfg_dst_rows),
    .src_dim (cfg_src_rows),
    .idx     (i),
    .src_idx (src_i),
    .last    (v_last),
    .oob     (v_oob)
  );

  assign fill = v_oob || h_oob;

  // Fields are forced to zero outside RUN so idle/reset outputs stay quiet.
  always_comb begin
    req_fill     = run && fill;
    req_last     = run && v_last && h_last;
    req_src_addr = '0;
    req_dst_addr = '0;
    if (run) begin
      req_dst_addr = AW'(i) * AW'(cfg_dst_cols) + AW'(j);
      if (!fill) req_src_addr = AW'(src_i) * AW'(cfg_src_cols) + AW'(src_j);
    end
  end
endmodule

// File: tb/tb_scale_addr_sequencer.sv
// Randomized self-checking bench for scale_addr_sequencer against an arithmetic frame model.
module tb_scale_addr_sequencer;
  import scale_pkg::*;

  logic                clk = 1'b0;
  logic                rst, start, req_ready;
  dim_t                src_rows, src_cols, dst_rows, dst_cols;
  logic [STEP_W-1:0]   step_v, step_h;
  logic                busy, done, req_valid, req_fill, req_last;
  addr_t               req_src_addr, req_dst_addr;

  scale_addr_sequencer #(.DIM_W(DIM_W), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_rows(src_rows), .src_cols(src_cols), .dst_rows(dst_rows), .dst_cols(dst_cols),
    .step_v(step_v), .step_h(step_h),
    .busy(busy), .done(done), .req_valid(req_valid), .req_ready(req_ready),
    .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
    .req_fill(req_fill), .req_last(req_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_src[$], exp_dst[$], obs_src[$], obs_dst[$];
  bit exp_fill[$], exp_last[$], obs_fill[$], obs_last[$];

  // Reference: source coordinate of destination (i,j) is floor(i*step_v), floor(j*step_h).
  function automatic void build_expected(int sr, int sc, int dr, int dc, int stv, int sth);
    longint vi, hj;
    exp_src.delete(); exp_dst.delete(); exp_fill.delete(); exp_last.delete();
    for (int r = 0; r < dr; r++) begin
      for (int c = 0; c < dc; c++) begin
        vi = (longint'(r) * stv) >> FRAC;
        hj = (longint'(c) * sth) >> FRAC;
        exp_fill.push_back(vi >= sr || hj >= sc);
        exp_src.push_back((vi >= sr || hj >= sc) ? 0 : int'(vi * sc + hj));
        exp_dst.push_back(r * dc + c);
        exp_last.push_back(r == dr - 1 && c == dc - 1);
      end
    end
  endfunction

  task automatic set_cfg(input int sr, input int sc, input int dr, input int dc, input int stv, input int sth);
    src_rows = dim_t'(sr); src_cols = dim_t'(sc);
    dst_rows = dim_t'(dr); dst_cols = dim_t'(dc);
    step_v = STEP_W'(stv); step_h = STEP_W'(sth);
    build_expected(sr, sc, dr, dc, stv, sth);
  endtask

  // Drives one frame and records every accepted request; reports protocol observations.
  task automatic run_frame(input int ready_pct, input bit poke, output bit first_vld, output bit timeout,
                           output int stall_err, output bit done1, output bit done2);
    addr_t hs, hd;
    bit hf, hl, held, got_last;
    int cyc;
    held = 0; got_last = 0; cyc = 0; timeout = 0; stall_err = 0;
    obs_src.delete(); obs_dst.delete(); obs_fill.delete(); obs_last.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_vld = req_valid && busy;
    while (!got_last) begin
      if (cyc >= 2000) begin timeout = 1; break; end
      req_ready = ($urandom_range(99) < ready_pct);
      if (poke && cyc == 3) begin
        start = 1'b1; dst_cols = dst_cols + 3; src_cols = src_cols + 1; step_h = step_h + 5;
      end else begin
        start = 1'b0;
      end
      if (req_valid) begin
        if (held && {req_src_addr, req_dst_addr, req_fill, req_last} !== {hs, hd, hf, hl}) stall_err++;
        if (req_ready) begin
          obs_src.push_back(int'(req_src_addr)); obs_dst.push_back(int'(req_dst_addr));
          obs_fill.push_back(req_fill); obs_last.push_back(req_last);
          got_last = req_last; held = 0;
        end else begin
          held = 1; hs = req_src_addr; hd = req_dst_addr; hf = req_fill; hl = req_last;
        end
      end else begin
        stall_err++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_ready = 1'b0; start = 1'b0;
    done1 = done && busy && !req_valid;
    @(posedge clk); #1;
    done2 = !done && !busy && !req_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; req_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, req_valid, req_fill, req_last, req_src_addr, req_dst_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%0b done=%0b vld=%0b fill=%0b last=%0b src=%0d dst=%0d, expected all 0",
               busy, done, req_valid, req_fill, req_last, req_src_addr, req_dst_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_upscale();
    int tbl[16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
    bit fv, to, d1, d2; int se;
    set_cfg(2, 2, 4, 4, 'h080, 'h080);
    run_frame(100, 0, fv, to, se, d1, d2);
    n_checks++;
    if (to || obs_src.size() != 16) begin
      n_fail++; $display("FAIL upscale_count: got %0d requests (timeout=%0b), expected 16", obs_src.size(), to);
    end
    for (int k = 0; k < 16 && k < obs_src.size(); k++) begin
      n_checks++;
      if (obs_src[k] !== tbl[k] || obs_dst[k] !== k || obs_fill[k] !== 1'b0 || obs_last[k] !== (k == 15)) begin
        n_fail++;
        $display("FAIL upscale[%0d]: got src=%0d dst=%0d fill=%0b last=%0b, expected src=%0d dst=%0d fill=0 last=%0b",
                 k, obs_src[k], obs_dst[k], obs_fill[k], obs_last[k], tbl[k], k, k == 15);
      end
    end
    n_checks++;
    if ({fv, se == 0, d1, d2} !== 4'b1111) begin
      n_fail++; $display("FAIL upscale_protocol: got first_vld=%0b stall_err=%0d done_pulse=%0b idle_after=%0b, expected 1 0 1 1", fv, se, d1, d2);
    end
  endtask

  task automatic test_downscale();
    bit fv, to, d1, d2; int se;
    set_cfg(4, 4, 2, 2, 'h200, 'h200);
    run_frame(100, 0, fv, to, se, d1, d2);
    n_checks++;
    if (to || obs_src.size() != exp_src.size()) begin
      n_fail++; $display("FAIL downscale_count: got %0d requests (timeout=%0b), expected %0d", obs_src.size(), to, exp_src.size());
    end
    for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
      n_checks++;
      if (obs_src[k] !== exp_src[k] || obs_dst[k] !== exp_dst[k] || obs_fill[k] !== exp_fill[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL downscale[%0d]: got src=%0d dst=%0d fill=%0b last=%0b, expected src=%0d dst=%0d fill=%0b last=%0b",
                 k, obs_src[k], obs_dst[k], obs_fill[k], obs_last[k], exp_src[k], exp_dst[k], exp_fill[k], exp_last[k]);
      end
    end
    n_checks++;
    if ({d1, d2} !== 2'b11) begin
      n_fail++; $display("FAIL downscale_done: got done_pulse=%0b idle_after=%0b, expected 1 1", d1, d2);
    end
  endtask

  task automatic test_oob();
    bit fv, to, d1, d2; int se, nfill;
    set_cfg(2, 2, 3, 3, 'h100, 'h100);
    run_frame(100, 0, fv, to, se, d1, d2);
    nfill = 0;
    n_checks++;
    if (to || obs_src.size() != 9) begin
      n_fail++; $display("FAIL oob_count: got %0d requests (timeout=%0b), expected 9", obs_src.size(), to);
    end
    for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
      nfill += obs_fill[k];
      n_checks++;
      if (obs_src[k] !== exp_src[k] || obs_dst[k] !== exp_dst[k] || obs_fill[k] !== exp_fill[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL oob[%0d]: got src=%0d dst=%0d fill=%0b last=%0b, expected src=%0d dst=%0d fill=%0b last=%0b",
                 k, obs_src[k], obs_dst[k], obs_fill[k], obs_last[k], exp_src[k], exp_dst[k], exp_fill[k], exp_last[k]);
      end
    end
    n_checks++;
    if (nfill !== 5) begin
      n_fail++; $display("FAIL oob_fill_count: got %0d fill requests, expected 5", nfill);
    end
  endtask

  task automatic test_backpressure();
    bit fv, to, d1, d2; int se;
    set_cfg(2, 2, 4, 4, 'h080, 'h080);
    run_frame(50, 1, fv, to, se, d1, d2);
    n_checks++;
    if (to || obs_src.size() != exp_src.size()) begin
      n_fail++; $display("FAIL backpressure_count: got %0d requests (timeout=%0b), expected %0d", obs_src.size(), to, exp_src.size());
    end
    for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
      n_checks++;
      if (obs_src[k] !== exp_src[k] || obs_dst[k] !== exp_dst[k] || obs_fill[k] !== exp_fill[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got src=%0d dst=%0d fill=%0b last=%0b, expected src=%0d dst=%0d fill=%0b last=%0b",
                 k, obs_src[k], obs_dst[k], obs_fill[k], obs_last[k], exp_src[k], exp_dst[k], exp_fill[k], exp_last[k]);
      end
    end
    n_checks++;
    if (se !== 0 || {d1, d2} !== 2'b11) begin
      n_fail++; $display("FAIL backpressure_stall: got stall_err=%0d done_pulse=%0b idle_after=%0b, expected 0 1 1", se, d1, d2);
    end
  endtask

  task automatic test_zero_size();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) set_cfg(2, 2, 3, 0, 'h100, 'h100);
      else        set_cfg(2, 2, 0, 3, 'h100, 'h100);
      start = 1'b1; req_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if ({done, busy, req_valid} !== 3'b110) begin
        n_fail++; $display("FAIL zero_size_done[%0d]: got done=%0b busy=%0b vld=%0b, expected 1 1 0", v, done, busy, req_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({done, busy, req_valid} !== 3'b000) begin
        n_fail++; $display("FAIL zero_size_idle[%0d]: got done=%0b busy=%0b vld=%0b, expected 0 0 0", v, done, busy, req_valid);
      end
      req_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    bit fv, to, d1, d2; int se;
    set_cfg(2, 2, 4, 4, 'h080, 'h080);
    start = 1'b1; req_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_ready = 1'b0;
    n_checks++;
    if ({busy, done, req_valid, req_fill, req_last, req_src_addr, req_dst_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got busy=%0b done=%0b vld=%0b fill=%0b last=%0b src=%0d dst=%0d, expected all 0",
               busy, done, req_valid, req_fill, req_last, req_src_addr, req_dst_addr);
    end
    run_frame(100, 0, fv, to, se, d1, d2);
    n_checks++;
    if (to || obs_dst.size() != exp_dst.size()) begin
      n_fail++; $display("FAIL restart_count: got %0d requests (timeout=%0b), expected %0d", obs_dst.size(), to, exp_dst.size());
    end
    for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
      n_checks++;
      if (obs_src[k] !== exp_src[k] || obs_dst[k] !== exp_dst[k] || obs_last[k] !== exp_last[k]) begin
        n_fail++;
        $display("FAIL restart[%0d]: got src=%0d dst=%0d last=%0b, expected src=%0d dst=%0d last=%0b",
                 k, obs_src[k], obs_dst[k], obs_last[k], exp_src[k], exp_dst[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_random();
    bit fv, to, d1, d2; int se;
    for (int f = 0; f < 6; f++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(1, 6), $urandom_range(1, 6),
              $urandom_range(0, 'h300), $urandom_range(0, 'h300));
      run_frame(60, 0, fv, to, se, d1, d2);
      n_checks++;
      if (to || obs_src.size() != exp_src.size() || se != 0 || {fv, d1, d2} !== 3'b111) begin
        n_fail++;
        $display("FAIL random%0d_frame: got %0d requests timeout=%0b stall_err=%0d first=%0b done=%0b idle=%0b, expected %0d requests 0 0 1 1 1",
                 f, obs_src.size(), to, se, fv, d1, d2, exp_src.size());
      end
      for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
        n_checks++;
        if (obs_src[k] !== exp_src[k] || obs_dst[k] !== exp_dst[k] || obs_fill[k] !== exp_fill[k] || obs_last[k] !== exp_last[k]) begin
          n_fail++;
          $display("FAIL random%0d[%0d]: got src=%0d dst=%0d fill=%0b last=%0b, expected src=%0d dst=%0d fill=%0b last=%0b",
                   f, k, obs_src[k], obs_dst[k], obs_fill[k], obs_last[k], exp_src[k], exp_dst[k], exp_fill[k], exp_last[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_upscale();
    test_downscale();
    test_oob();
    test_backpressure();
    test_zero_size();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
